// File: rtl/rf_scan_pkg.sv
// Shared definitions for the register-file scanner: widths and FSM encoding.
// Optional checksum beat is enabled by defining RF_SCAN_CKSUM_EN.
package rf_scan_pkg;

    localparam int XLEN_D   = 32;
    localparam int RF_NUM_D = 32;
    localparam int IDX_W    = $clog2(RF_NUM_D);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        SEND  = 3'd2,
        CKSUM = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rf_scan_out_reg.sv
// Output beat register: loads a new beat, holds it while stalled, clear withdraws it.
module rf_scan_out_reg
    import rf_scan_pkg::*;
#(
    parameter int XLEN = XLEN_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [IDX_W-1:0] nxt_idx,
    input  logic [XLEN-1:0]  nxt_data,
    input  logic             nxt_last,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [XLEN-1:0]  data,
    output logic             last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            idx   <= '0;
            data  <= '0;
            last  <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            idx   <= nxt_idx;
            data  <= nxt_data;
            last  <= nxt_last;
        end
    end

endmodule

// File: rtl/rf_scan.sv
// Register-file dump engine: streams every register as one beat per cycle.
// Defining RF_SCAN_CKSUM_EN appends an XOR checksum beat after the last register.
module rf_scan
    import rf_scan_pkg::*;
#(
    parameter int XLEN   = XLEN_D,
    parameter int RF_NUM = RF_NUM_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [IDX_W-1:0] rf_addr,
    input  logic [XLEN-1:0]  rf_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [XLEN-1:0]  out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RF_NUM - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
`ifdef RF_SCAN_CKSUM_EN
    logic [XLEN-1:0]  cksum;
`endif

    logic             ld;
    logic             clr;
    logic [IDX_W-1:0] ld_idx;
    logic [XLEN-1:0]  ld_data;
    logic             ld_last;

    assign idx_inc = idx + 1'b1;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    // Handshake: a beat transfers on a rising edge with out_valid && out_ready;
    // while out_valid=1 and out_ready=0 the beat is held unchanged; abort withdraws it.
    always_comb begin
        rf_addr = idx;
        ld      = 1'b0;
        clr     = 1'b0;
        ld_idx  = idx;
        ld_data = rf_data;
        ld_last = 1'b0;
        if (state == SEND && idx != LAST_IDX) begin
            rf_addr = idx_inc;
        end
        if (abort) begin
            clr = 1'b1;
        end else begin
            case (state)
                READ: begin
                    ld = 1'b1;
`ifndef RF_SCAN_CKSUM_EN
                    ld_last = (idx == LAST_IDX);
`endif
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx != LAST_IDX) begin
                            ld     = 1'b1;
                            ld_idx = idx_inc;
`ifndef RF_SCAN_CKSUM_EN
                            ld_last = (idx_inc == LAST_IDX);
`endif
                        end else begin
`ifdef RF_SCAN_CKSUM_EN
                            ld      = 1'b1;
                            ld_idx  = '0;
                            ld_data = cksum;
                            ld_last = 1'b1;
`else
                            clr = 1'b1;
`endif
                        end
                    end
                end
                CKSUM: begin
                    if (out_ready) begin
                        clr = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
`ifdef RF_SCAN_CKSUM_EN
            cksum <= '0;
`endif
        end else if (abort) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        idx   <= '0;
`ifdef RF_SCAN_CKSUM_EN
                        cksum <= '0;
`endif
                    end
                end
                READ: begin
                    state <= SEND;
`ifdef RF_SCAN_CKSUM_EN
                    cksum <= cksum ^ rf_data;
`endif
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx != LAST_IDX) begin
                            idx <= idx_inc;
`ifdef RF_SCAN_CKSUM_EN
                            cksum <= cksum ^ rf_data;
`endif
                        end else begin
`ifdef RF_SCAN_CKSUM_EN
                            state <= CKSUM;
`else
                            state <= DONE;
`endif
                        end
                    end
                end
                CKSUM: begin
                    if (out_ready) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    rf_scan_out_reg #(.XLEN(XLEN)) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .clear    (clr),
        .nxt_idx  (ld_idx),
        .nxt_data (ld_data),
        .nxt_last (ld_last),
        .valid    (out_valid),
        .idx      (out_idx),
        .data     (out_data),
        .last     (out_last)
    );

endmodule

// File: tb/tb_rf_scan.sv
// Self-checking bench for rf_scan: expected beat list built from the register array.
// Honours RF_SCAN_CKSUM_EN the same way the design does.
module tb_rf_scan;
    import rf_scan_pkg::*;

    localparam int W = 1 + IDX_W + XLEN_D;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              out_ready = 1'b0;
    logic [IDX_W-1:0]  rf_addr;
    logic [XLEN_D-1:0] rf_data;
    logic              out_valid;
    logic [IDX_W-1:0]  out_idx;
    logic [XLEN_D-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    logic [XLEN_D-1:0] rf [RF_NUM_D];
    logic [W-1:0]      exp_q[$];
    logic [W-1:0]      got_q[$];
    int                stamp_q[$];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                done_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign rf_data = rf[rf_addr];

    rf_scan dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // Monitor: a beat presented with ready high (and no abort) is taken at the next edge.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready && !abort) begin
                got_q.push_back({out_last, out_idx, out_data});
                stamp_q.push_back(cyc);
            end
            if (done) done_cnt++;
        end
    end

    task automatic build_exp();
`ifdef RF_SCAN_CKSUM_EN
        logic [XLEN_D-1:0] x = '0;
`endif
        exp_q.delete();
        for (int i = 0; i < RF_NUM_D; i++) begin
`ifdef RF_SCAN_CKSUM_EN
            x = x ^ rf[i];
            exp_q.push_back({1'b0, IDX_W'(i), rf[i]});
`else
            exp_q.push_back({(i == RF_NUM_D - 1), IDX_W'(i), rf[i]});
`endif
        end
`ifdef RF_SCAN_CKSUM_EN
        exp_q.push_back({1'b1, {IDX_W{1'b0}}, x});
`endif
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0 = done_cnt;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk); #1;
            if (done_cnt > d0) ok = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int c = 0; c < budget && got_q.size() < n; c++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic fresh();
        got_q.delete();
        stamp_q.delete();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({out_valid, out_idx, out_data, out_last, busy, done, rf_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b idx=%0d data=%h last=%0b busy=%0b done=%0b addr=%0d, required all 0",
                     out_valid, out_idx, out_data, out_last, busy, done, rf_addr);
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%0b valid=%0b, required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int d0;
        for (int i = 0; i < RF_NUM_D; i++) rf[i] = XLEN_D'(i * 16);
        fresh();
        build_exp();
        out_ready = 1'b1;
        d0 = done_cnt;
        pulse_start();
        wait_done(200, ok);
        checks++;
        if (!ok || done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL basic_done: done pulses %0d, required 1", done_cnt - d0);
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d beats, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < stamp_q.size(); i++) begin
            checks++;
            if (stamp_q[i] !== stamp_q[0] + i) begin
                errors++;
                $display("FAIL basic_rate%0d: beat at cycle %0d, required %0d", i, stamp_q[i], stamp_q[0] + i);
            end
        end
    endtask

    task automatic test_stall();
        bit              have_prev = 1'b0;
        bit              prev_valid = 1'b0;
        bit              prev_ready = 1'b0;
        logic [W-1:0]    prev_beat = '0;
        int              d0;
        int              ph = 0;
        for (int i = 0; i < RF_NUM_D; i++) rf[i] = $urandom;
        fresh();
        build_exp();
        out_ready = 1'b1;
        d0 = done_cnt;
        pulse_start();
        for (int c = 0; c < 600 && done_cnt == d0; c++) begin
            out_ready = (ph % 4 == 0) || (ph % 4 == 3);
            ph++;
            @(negedge clk); #1;
            if (have_prev && prev_valid && !prev_ready && out_valid) begin
                checks++;
                if ({out_last, out_idx, out_data} !== prev_beat) begin
                    errors++;
                    $display("FAIL stall_hold: beat %h changed while stalled, required %h",
                             {out_last, out_idx, out_data}, prev_beat);
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_beat  = {out_last, out_idx, out_data};
            have_prev  = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        checks++;
        if (done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL stall_done: done pulses %0d, required 1", done_cnt - d0);
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL stall_count: got %0d beats, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        int d0;
        for (int i = 0; i < RF_NUM_D; i++) rf[i] = $urandom;
        fresh();
        out_ready = 1'b1;
        d0 = done_cnt;
        pulse_start();
        wait_beats(6, 100);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: valid=%0b busy=%0b, required 0 0", out_valid, busy);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== d0 || got_q.size() !== 6) begin
            errors++;
            $display("FAIL abort_quiet: done pulses %0d beats %0d, required 0 and 6", done_cnt - d0, got_q.size());
        end
        fresh();
        build_exp();
        pulse_start();
        wait_done(200, ok);
        checks++;
        if (!ok || got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL abort_redump_count: got %0d beats, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_redump_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_busy();
        bit ok;
        int d0;
        int n;
        for (int i = 0; i < RF_NUM_D; i++) rf[i] = $urandom;
        fresh();
        build_exp();
        out_ready = 1'b1;
        d0 = done_cnt;
        pulse_start();
        wait_beats(11, 100);
        pulse_start();
        wait_done(200, ok);
        n = got_q.size();
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== d0 + 1 || busy !== 1'b0 || got_q.size() !== n) begin
            errors++;
            $display("FAIL busy_start_ignored: done pulses %0d busy=%0b extra beats %0d, required 1 0 0",
                     done_cnt - d0, busy, got_q.size() - n);
        end
        checks++;
        if (n !== exp_q.size()) begin
            errors++;
            $display("FAIL busy_start_count: got %0d beats, required %0d", n, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL busy_start_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        fresh();
        out_ready = 1'b1;
        d0 = done_cnt;
        pulse_start();
        wait_beats(21, 100);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_idx, out_data, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: valid=%0b idx=%0d data=%h last=%0b busy=%0b done=%0b, required all 0",
                     out_valid, out_idx, out_data, out_last, busy, done);
        end
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done_cnt !== d0) begin
            errors++;
            $display("FAIL reset_mid_idle: busy=%0b valid=%0b done pulses %0d, required 0 0 0",
                     busy, out_valid, done_cnt - d0);
        end
    endtask

    task automatic test_rewrite();
        bit ok;
        for (int i = 0; i < RF_NUM_D; i++) rf[i] = XLEN_D'(i * 16);
        rf[6] = 32'h7;
        fresh();
        out_ready = 1'b1;
        pulse_start();
        rf[6] = 32'h9;
        build_exp();
        wait_done(200, ok);
        checks++;
        if (!ok || got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rewrite_count: got %0d beats, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rewrite_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_idle_start_abort();
        fresh();
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || got_q.size() !== 0) begin
            errors++;
            $display("FAIL start_abort_idle: busy=%0b valid=%0b beats %0d, required 0 0 0",
                     busy, out_valid, got_q.size());
        end
    endtask

    task automatic test_random_ready();
        int d0;
        for (int i = 0; i < RF_NUM_D; i++) rf[i] = $urandom;
        fresh();
        build_exp();
        out_ready = 1'b1;
        d0 = done_cnt;
        pulse_start();
        for (int c = 0; c < 800 && done_cnt == d0; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        checks++;
        if (done_cnt !== d0 + 1 || got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL random_count: done pulses %0d beats %0d, required 1 and %0d",
                     done_cnt - d0, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < RF_NUM_D; i++) rf[i] = '0;
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_start_busy();
        test_reset_mid();
        test_rewrite();
        test_idle_start_abort();
        test_random_ready();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
